// File: rtl/spi_mem_fsm_if.sv
// SPI memory control bundle: conditioned SPI events in, datapath enables out.
// Latency: none, wires only.
// Backpressure: none; the FSM samples the events every clk cycle.
interface spi_mem_fsm_if;
  logic       cs_n;
  logic       sclk_pos;
  logic       sclk_neg;
  logic       rw_bit;
  logic       addr_we;
  logic       sr_we;
  logic       dm_we;
  logic       miso_buff_en;
  logic [2:0] state_dbg;

  // Event source side: input conditioners and shift register.
  modport master (
    output cs_n, sclk_pos, sclk_neg, rw_bit,
    input  addr_we, sr_we, dm_we, miso_buff_en, state_dbg
  );

  // Control FSM side.
  modport slave (
    input  cs_n, sclk_pos, sclk_neg, rw_bit,
    output addr_we, sr_we, dm_we, miso_buff_en, state_dbg
  );
endinterface

// File: rtl/spi_mem_fsm.sv
// Control FSM for the SPI memory: sequences address latch, shift register, memory and MISO.
// Latency: Moore outputs, 1 cycle from the deciding input event to the enable.
// Backpressure: none; SCLK edge pulses are counted in the cycle they arrive.
module spi_mem_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_fsm_if.slave      bus
);

  // The counter must reach the longer of the address phase (address + R/W bit) and the data phase.
  localparam int MAX_BITS = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  // The last counting edge of a phase is the one seen while the counter holds (phase length - 1).
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and bit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; chip-select release overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = GET_ADDR;
        GET_ADDR: begin
          if (bus.sclk_pos) begin
            if (cnt_q == ADDR_LAST) state_d = GOT_ADDR;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        GOT_ADDR:  state_d = bus.rw_bit ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD: state_d = READ_SHIFT;
        READ_SHIFT: begin
          if (bus.sclk_neg) begin
            if (cnt_q == DATA_LAST) state_d = DONE;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        WRITE_SHIFT: begin
          if (bus.sclk_pos) begin
            if (cnt_q == DATA_LAST) state_d = WRITE_MEM;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        WRITE_MEM: state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
    // Every phase starts counting from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // Moore output decode of the registered state.
  always_comb begin
    bus.addr_we      = 1'b0;
    bus.sr_we        = 1'b0;
    bus.dm_we        = 1'b0;
    bus.miso_buff_en = 1'b0;
    bus.state_dbg    = state_q;
    unique case (state_q)
      GOT_ADDR:   bus.addr_we      = 1'b1;
      READ_LOAD:  bus.sr_we        = 1'b1;
      WRITE_MEM:  bus.dm_we        = 1'b1;
      READ_SHIFT: bus.miso_buff_en = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Bench for spi_mem_fsm: per-cycle stimulus schedules with expected states derived from
// the transaction structure (address edges, R/W choice, data edges, chip-select release).
// Random gaps, ignored-edge noise and aborts are mixed in.
module tb_spi_mem_fsm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_mem_fsm_if bus ();

  spi_mem_fsm #(.ADDR_BITS(7), .DATA_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Schedule: inputs applied for one cycle and the state expected after that clock edge.
  bit q_cs[$];
  bit q_pos[$];
  bit q_neg[$];
  bit q_rw[$];
  int q_exp[$];

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected {addr_we, sr_we, dm_we, miso_buff_en} for a given state number.
  function automatic logic [3:0] outs_for(int st);
    case (st)
      2:       return 4'b1000;
      3:       return 4'b0100;
      6:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic push(input bit cs, input bit pos, input bit neg, input bit rw, input int st);
    q_cs.push_back(cs);
    q_pos.push_back(pos);
    q_neg.push_back(neg);
    q_rw.push_back(rw);
    q_exp.push_back(st);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sched(input string tag);
    for (int i = 0; i < q_exp.size(); i++) begin
      @(negedge clk);
      bus.cs_n     = q_cs[i];
      bus.sclk_pos = q_pos[i];
      bus.sclk_neg = q_neg[i];
      bus.rw_bit   = q_rw[i];
      @(posedge clk);
      #1;
      check({tag, "_state"}, {1'b0, bus.state_dbg}, 4'(q_exp[i]));
      check({tag, "_outs"}, {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff_en},
            outs_for(q_exp[i]));
    end
    q_cs.delete(); q_pos.delete(); q_neg.delete(); q_rw.delete(); q_exp.delete();
  endtask

  // cs_n falls, 8 address-phase rising edges (falling-edge noise between), then the R/W decision.
  task automatic gen_addr(input bit rd);
    push(1'b0, 1'b0, 1'b0, rb(), 1);
    for (int k = 1; k <= 8; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) push(1'b0, 1'b0, rb(), rb(), 1);
      push(1'b0, 1'b1, rb(), rb(), (k == 8) ? 2 : 1);
    end
    push(1'b0, rb(), rb(), rd, rd ? 3 : 5);
  endtask

  // Parallel load then 8 falling edges with rising-edge noise between.
  task automatic gen_read(input int nbits);
    push(1'b0, rb(), rb(), rb(), 4);
    for (int k = 1; k <= nbits; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) push(1'b0, rb(), 1'b0, rb(), 4);
      push(1'b0, rb(), 1'b1, rb(), (k == 8) ? 7 : 4);
    end
  endtask

  // 8 data rising edges; abort_k in 1..8 releases cs_n on that edge instead.
  task automatic gen_write(input int abort_k);
    for (int k = 1; k <= 8; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) push(1'b0, 1'b0, rb(), rb(), 5);
      if (k == abort_k) begin
        push(1'b1, 1'b1, rb(), rb(), 0);
        return;
      end
      push(1'b0, 1'b1, rb(), rb(), (k == 8) ? 6 : 5);
    end
    push(1'b0, rb(), rb(), rb(), 7);
  endtask

  task automatic gen_done(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rb(), 7);
    push(1'b1, rb(), rb(), rb(), 0);
  endtask

  initial begin
    bus.cs_n     = 1'b1;
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    bus.rw_bit   = 1'b0;
    rst_n        = 1'b0;

    // Reset state.
    #12;
    check("reset_state", {1'b0, bus.state_dbg}, 4'd0);
    check("reset_outs", {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff_en}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 0);
    push(1'b1, 1'b1, 1'b1, 1'b1, 0);
    run_sched("idle");

    // Async reset in the middle of a read data phase.
    gen_addr(1'b1);
    gen_read(3);
    run_sched("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {1'b0, bus.state_dbg}, 4'd0);
    check("async_rst_outs", {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff_en}, 4'b0000);
    bus.cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_sched("post_rst");

    // Full write, then full read.
    gen_addr(1'b0);
    gen_write(0);
    gen_done(3);
    run_sched("write");
    gen_addr(1'b1);
    gen_read(8);
    gen_done(2);
    run_sched("read");

    // Abort on the last write data edge.
    gen_addr(1'b0);
    gen_write(8);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_sched("abort");

    // Simultaneous edges in the address phase count once: 8 double pulses finish it.
    push(1'b0, 1'b0, 1'b0, 1'b0, 1);
    for (int k = 1; k <= 8; k++) push(1'b0, 1'b1, 1'b1, 1'b0, (k == 8) ? 2 : 1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3);
    gen_read(8);
    gen_done(1);
    run_sched("both_edges");

    // Long DONE dwell, one-cycle release, back-to-back transaction.
    gen_addr(1'b0);
    gen_write(0);
    gen_done(20);
    gen_addr(1'b1);
    gen_read(8);
    gen_done(2);
    run_sched("b2b");

    // Random mix of reads, writes and aborts.
    for (int t = 0; t < 8; t++) begin
      bit rd;
      rd = rb();
      gen_addr(rd);
      if (rd) begin
        gen_read(8);
        gen_done($urandom_range(0, 4));
      end else if ($urandom_range(0, 2) == 0) begin
        gen_write($urandom_range(1, 8));
      end else begin
        gen_write(0);
        gen_done($urandom_range(0, 4));
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) push(1'b1, rb(), rb(), rb(), 0);
      run_sched("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
